f_fetch_unit: RTL and testbench

F_FETCH_UNIT -- requirements
Module: f_fetch_unit

---
 rtl/f_fetch_unit_pkg.sv | 15 +
 rtl/f_fetch_unit.sv | 123 ++++++++++++
 tb/tb_f_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/f_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: reset PC, PC step,
// the nop encoding and the fetch FSM state encoding.
package f_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/f_fetch_unit.sv
// Instruction fetch stage: issues one memory read per instruction, presents
// the result to Decode and honours stall and redirect from downstream.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = f_fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] PC_STEP  = f_fetch_unit_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instr,
    output logic        F_valid
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic [31:0]  target_reg;
    logic         kill_reg;
    logic         im_req_reg;
    logic [31:0]  f_pc_reg;
    logic [31:0]  f_instr_reg;
    logic         f_valid_reg;

    logic [31:0]  redirect_target;
    logic [31:0]  pc_seq;
    logic         unused_bits;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign pc_seq          = pc_reg + PC_STEP;
    assign unused_bits     = ^redirect_pc[1:0];

    // Next-PC mux. While a request is outstanding the address must stay put,
    // so a redirect there only takes effect once the response has completed.
    always_comb begin
        pc_next = pc_reg;
        case (state_reg)
            REQ: begin
                if (im_ready) begin
                    if (redirect) begin
                        pc_next = redirect_target;
                    end else if (kill_reg) begin
                        pc_next = target_reg;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next = redirect_target;
                end else if (!stall) begin
                    pc_next = pc_seq;
                end
            end
            default: pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            target_reg  <= RESET_PC;
            kill_reg    <= 1'b0;
            im_req_reg  <= 1'b0;
            f_pc_reg    <= RESET_PC;
            f_instr_reg <= NOP;
            f_valid_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            case (state_reg)
                IDLE: begin
                    state_reg  <= REQ;
                    im_req_reg <= 1'b1;
                end
                REQ: begin
                    if (im_ready) begin
                        if (redirect || kill_reg) begin
                            // Response belongs to a squashed path: drop it and
                            // re-request at the new target.
                            kill_reg <= 1'b0;
                        end else begin
                            state_reg   <= HOLD;
                            im_req_reg  <= 1'b0;
                            f_pc_reg    <= pc_reg;
                            f_instr_reg <= im_rdata;
                            f_valid_reg <= 1'b1;
                        end
                    end else if (redirect) begin
                        target_reg <= redirect_target;
                        kill_reg   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        state_reg   <= REQ;
                        im_req_reg  <= 1'b1;
                        f_instr_reg <= NOP;
                        f_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    im_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign im_req  = im_req_reg;
    assign im_addr = pc_reg;
    assign F_PC    = f_pc_reg;
    assign F_Instr = f_instr_reg;
    assign F_valid = f_valid_reg;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed scenarios with constant
// expectations plus a randomized run checked against a behavioural model.
module tb_f_fetch_unit;

    localparam logic [31:0] RST  = 32'h0000_3000;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        im_ready = 1'b0;
    logic [31:0] im_rdata = 32'h0;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what the fetch stage should be showing right now.
    bit          m_boot;
    bit          m_have;
    bit          m_kill;
    logic [31:0] m_pc;
    logic [31:0] m_target;
    logic [31:0] m_fpc;
    logic [31:0] m_finstr;

    f_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr),
        .im_ready(im_ready), .im_rdata(im_rdata), .F_PC(F_PC),
        .F_Instr(F_Instr), .F_valid(F_valid)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, updating the model with the inputs seen there.
    task automatic tick();
        logic [31:0] tgt;
        @(posedge clk);
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (!reset) begin
            m_boot = 1; m_have = 0; m_kill = 0;
            m_pc = RST; m_target = RST; m_fpc = RST; m_finstr = 32'h0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_have) begin
            if (im_ready) begin
                if (redirect) begin
                    m_pc = tgt; m_kill = 0;
                end else if (m_kill) begin
                    m_pc = m_target; m_kill = 0;
                end else begin
                    m_have = 1; m_fpc = m_pc; m_finstr = im_rdata;
                end
            end else if (redirect) begin
                m_target = tgt; m_kill = 1;
            end
        end else begin
            if (redirect) begin
                m_pc = tgt; m_have = 0; m_finstr = 32'h0;
            end else if (!stall) begin
                m_pc = m_pc + STEP; m_have = 0; m_finstr = 32'h0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 0; stall = 0; redirect = 0; im_ready = 0;
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        reset = 0; stall = 1; redirect = 1; redirect_pc = 32'h5000; im_ready = 1;
        tick();
        tick();
        checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL reset_im_req got %0b want 0", im_req); end
        checks++; if (im_addr !== RST) begin errors++; $display("FAIL reset_im_addr got %h want %h", im_addr, RST); end
        checks++; if (F_PC !== RST) begin errors++; $display("FAIL reset_F_PC got %h want %h", F_PC, RST); end
        checks++; if (F_Instr !== 32'h0) begin errors++; $display("FAIL reset_F_Instr got %h want 0", F_Instr); end
        checks++; if (F_valid !== 1'b0) begin errors++; $display("FAIL reset_F_valid got %0b want 0", F_valid); end
        stall = 0; redirect = 0; im_ready = 0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] d;
        reset = 1; im_ready = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (im_req !== 1'b1 || im_addr !== RST + 4 * k || F_valid !== 1'b0 || F_Instr !== 32'h0) begin
                errors++;
                $display("FAIL zero_wait_req%0d got req=%0b addr=%h v=%0b ins=%h want 1 %h 0 0", k, im_req, im_addr, F_valid, F_Instr, RST + 4 * k);
            end
            d = $urandom;
            im_rdata = d;
            tick();
            checks++;
            if (F_valid !== 1'b1 || F_PC !== RST + 4 * k || F_Instr !== d || im_req !== 1'b0) begin
                errors++;
                $display("FAIL zero_wait_out%0d got v=%0b pc=%h ins=%h req=%0b want 1 %h %h 0", k, F_valid, F_PC, F_Instr, im_req, RST + 4 * k, d);
            end
            tick();
        end
        $display("zero_wait: three sequential fetches done");
    endtask

    task automatic test_stall();
        logic [31:0] d;
        do_reset();
        im_ready = 1;
        tick();
        tick();
        d = $urandom;
        im_rdata = d;
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            im_rdata = $urandom;
            tick();
            checks++;
            if (F_PC !== 32'h3004 || F_Instr !== d || F_valid !== 1'b1 || im_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got pc=%h ins=%h v=%0b req=%0b want 3004 %h 1 0", k, F_PC, F_Instr, F_valid, im_req, d);
            end
        end
        stall = 0;
        tick();
        checks++;
        if (im_req !== 1'b1 || im_addr !== 32'h3008 || F_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got req=%0b addr=%h v=%0b want 1 3008 0", im_req, im_addr, F_valid);
        end
        $display("stall: held three cycles then advanced");
    endtask

    task automatic test_wait_redirect();
        do_reset();
        im_ready = 0;
        redirect = 1; redirect_pc = 32'h3101;
        for (int k = 0; k < 3; k++) begin
            tick();
            redirect = 0;
            checks++;
            if (im_req !== 1'b1 || im_addr !== RST) begin
                errors++;
                $display("FAIL wait_redirect_hold%0d got req=%0b addr=%h want 1 %h", k, im_req, im_addr, RST);
            end
        end
        im_ready = 1; im_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (F_valid !== 1'b0 || F_Instr !== 32'h0 || im_req !== 1'b1 || im_addr !== 32'h3100) begin
            errors++;
            $display("FAIL wait_redirect_discard got v=%0b ins=%h req=%0b addr=%h want 0 0 1 3100", F_valid, F_Instr, im_req, im_addr);
        end
        im_rdata = 32'h1234_5678;
        tick();
        checks++;
        if (F_valid !== 1'b1 || F_PC !== 32'h3100 || F_Instr !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wait_redirect_fetch got v=%0b pc=%h ins=%h want 1 3100 12345678", F_valid, F_PC, F_Instr);
        end
        $display("wait_redirect: stale response dropped, refetch at 3100");
    endtask

    task automatic test_redirect_stall();
        do_reset();
        im_ready = 1;
        tick();
        stall = 1; redirect = 1; redirect_pc = 32'h4000;
        tick();
        stall = 0; redirect = 0;
        checks++;
        if (im_req !== 1'b1 || im_addr !== 32'h4000 || F_valid !== 1'b0 || F_Instr !== 32'h0) begin
            errors++;
            $display("FAIL redirect_stall got req=%0b addr=%h v=%0b ins=%h want 1 4000 0 0", im_req, im_addr, F_valid, F_Instr);
        end
        $display("redirect_stall: redirect overrides stall");
    endtask

    task automatic test_wrap();
        do_reset();
        im_ready = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 0;
        checks++;
        if (im_addr !== 32'hFFFF_FFFC || F_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_target got addr=%h v=%0b want fffffffc 0", im_addr, F_valid);
        end
        tick();
        tick();
        checks++;
        if (im_req !== 1'b1 || im_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_advance got req=%0b addr=%h want 1 00000000", im_req, im_addr);
        end
        $display("wrap: pc wrapped to zero");
    endtask

    task automatic test_reset_mid();
        do_reset();
        im_ready = 0;
        tick();
        reset = 0; im_ready = 1; redirect = 1; redirect_pc = $urandom;
        tick();
        redirect = 0;
        checks++;
        if (im_req !== 1'b0 || im_addr !== RST || F_PC !== RST || F_Instr !== 32'h0 || F_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got req=%0b addr=%h pc=%h ins=%h v=%0b want 0 %h %h 0 0", im_req, im_addr, F_PC, F_Instr, F_valid, RST, RST);
        end
        reset = 1;
        tick();
        checks++;
        if (F_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== RST) begin
            errors++;
            $display("FAIL reset_mid_idle got v=%0b req=%0b addr=%h want 0 1 %h", F_valid, im_req, im_addr, RST);
        end
        $display("reset_mid: pending response ignored");
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 63) != 0);
            stall       = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            im_ready    = $urandom_range(0, 1) == 1;
            im_rdata    = $urandom;
            tick();
            checks++;
            if (im_req !== (!m_boot && !m_have) || im_addr !== m_pc || F_valid !== m_have ||
                F_PC !== m_fpc || F_Instr !== (m_have ? m_finstr : 32'h0)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle%0d got req=%0b addr=%h v=%0b pc=%h ins=%h want %0b %h %0b %h %h",
                             n, im_req, im_addr, F_valid, F_PC, F_Instr, (!m_boot && !m_have), m_pc, m_have, m_fpc,
                             (m_have ? m_finstr : 32'h0));
            end
        end
        reset = 1; stall = 0; redirect = 0; im_ready = 0;
        $display("random: 3000 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
